// File: rtl/wb_dbg_master_if.sv
// Wishbone initiator-side bus bundle used by the debug master and its slaves.
// The master drives address/data/strobe; the slave returns read data and ack.
interface wb_dbg_master_if #(
  parameter int AW = 16
);
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_wdata;
  logic [31:0]   wb_rdata;
  logic [3:0]    wb_wmsk;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/wb_dbg_master.sv
// Byte-stream command parser that issues single 32-bit Wishbone reads/writes
// and streams status plus read data back to a byte sink.
module wb_dbg_master #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_24m,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_stb,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  wb_dbg_master_if.master        wb,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        we_pend;
  logic [1:0]  byte_cnt;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] timer;
  logic [31:0] resp_buf;
  logic [2:0]  resp_cnt;

  logic [15:0] addr_shift;
  logic [31:0] wdata_shift;

  assign addr_shift  = {addr_q[7:0], rx_data};
  assign wdata_shift = {wdata_q[23:0], rx_data};

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      we_pend     <= 1'b0;
      byte_cnt    <= 2'd0;
      addr_q      <= 16'd0;
      wdata_q     <= 32'd0;
      timer       <= 16'd0;
      resp_buf    <= 32'd0;
      resp_cnt    <= 3'd0;
      tx_data     <= 8'd0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      wb.wb_addr  <= '0;
      wb.wb_wdata <= 32'd0;
      wb.wb_wmsk  <= 4'h0;
      wb.wb_we    <= 1'b0;
      wb.wb_cyc   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_stb && (rx_data == 8'h01 || rx_data == 8'h02)) begin
            state    <= S_ADDR;
            we_pend  <= (rx_data == 8'h01);
            byte_cnt <= 2'd0;
            busy     <= 1'b1;
          end
        end

        S_ADDR: begin
          if (rx_stb) begin
            addr_q   <= addr_shift;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd1) begin
              byte_cnt <= 2'd0;
              if (we_pend) begin
                state <= S_WDATA;
              end else begin
                // Reads launch straight from the address phase.
                state      <= S_BUS;
                wb.wb_addr <= addr_shift[AW-1:0];
                wb.wb_cyc  <= 1'b1;
                wb.wb_we   <= 1'b0;
                wb.wb_wmsk <= 4'h0;
                timer      <= 16'd0;
              end
            end
          end
        end

        S_WDATA: begin
          if (rx_stb) begin
            wdata_q  <= wdata_shift;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state       <= S_BUS;
              wb.wb_addr  <= addr_q[AW-1:0];
              wb.wb_wdata <= wdata_shift;
              wb.wb_cyc   <= 1'b1;
              wb.wb_we    <= 1'b1;
              wb.wb_wmsk  <= 4'hF;
              timer       <= 16'd0;
            end
          end
        end

        S_BUS: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (wb.wb_ack) begin
            wb.wb_cyc  <= 1'b0;
            wb.wb_we   <= 1'b0;
            wb.wb_wmsk <= 4'h0;
            tx_valid   <= 1'b1;
            state      <= S_RESP;
            if (we_pend) begin
              tx_data  <= 8'h81;
              resp_cnt <= 3'd1;
            end else begin
              tx_data  <= 8'h82;
              resp_buf <= wb.wb_rdata;
              resp_cnt <= 3'd5;
            end
          end else if (timer == TMO_LAST) begin
            wb.wb_cyc  <= 1'b0;
            wb.wb_we   <= 1'b0;
            wb.wb_wmsk <= 4'h0;
            tx_valid   <= 1'b1;
            tx_data    <= 8'hEE;
            resp_cnt   <= 3'd1;
            state      <= S_RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_RESP: begin
          if (tx_valid && tx_ready) begin
            if (resp_cnt == 3'd1) begin
              tx_valid <= 1'b0;
              resp_cnt <= 3'd0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_data  <= resp_buf[31:24];
              resp_buf <= {resp_buf[23:0], 8'h00};
              resp_cnt <= resp_cnt - 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for the Wishbone debug master: write, read, timeout,
// backpressure, garbage filtering and mid-cycle reset.
module tb_wb_dbg_master;

  localparam int AW      = 16;
  localparam int TIMEOUT = 16;

  logic       clk_24m = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  logic        bp_mode = 1'b0;
  logic        ack_on  = 1'b1;
  int          ack_wait = 0;
  int          wait_cnt = 0;
  logic [31:0] rdata_v = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  wb_dbg_master_if #(.AW(AW)) bus ();

  wb_dbg_master #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_24m  (clk_24m),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_stb   (rx_stb),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wb       (bus.master),
    .busy     (busy)
  );

  always #21 clk_24m = ~clk_24m;

  // Slave: acks (combinationally) after ack_wait wait cycles when enabled.
  assign bus.wb_ack   = bus.wb_cyc && ack_on && (wait_cnt == ack_wait);
  assign bus.wb_rdata = rdata_v;

  always @(posedge clk_24m)
    wait_cnt <= (bus.wb_cyc && !bus.wb_ack) ? wait_cnt + 1 : 0;

  // Sink: always ready, or ready for one cycle after 10 stalled cycles.
  initial begin
    int lowcnt;
    lowcnt   = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk_24m);
      #1;
      if (!bp_mode) tx_ready = 1'b1;
      else if (tx_ready) begin
        tx_ready = 1'b0;
        lowcnt   = 0;
      end else if (tx_valid) begin
        lowcnt++;
        if (lowcnt >= 10) tx_ready = 1'b1;
      end
    end
  end

  // Bus and byte-sink observers.
  int          cyc_cycles = 0, cyc_pulses = 0, bus_unstable = 0;
  int          tx_n = 0, tx_unstable = 0;
  logic [7:0]  tx_log [0:63];
  logic        cyc_prev = 1'b0, pv_valid = 1'b0, pv_acc = 1'b0;
  logic [7:0]  pv_data = 8'd0;
  logic [15:0] cap_addr = 16'd0;
  logic [31:0] cap_wdata = 32'd0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_wmsk = 4'h0;

  always @(negedge clk_24m) begin
    if (bus.wb_cyc) begin
      cyc_cycles++;
      if (!cyc_prev) begin
        cyc_pulses++;
        cap_addr  = bus.wb_addr;
        cap_wdata = bus.wb_wdata;
        cap_we    = bus.wb_we;
        cap_wmsk  = bus.wb_wmsk;
      end else if (bus.wb_addr !== cap_addr || bus.wb_wdata !== cap_wdata ||
                   bus.wb_we !== cap_we || bus.wb_wmsk !== cap_wmsk) begin
        bus_unstable++;
      end
    end
    cyc_prev = bus.wb_cyc;
    if (tx_valid && tx_ready && tx_n < 64) begin
      tx_log[tx_n] = tx_data;
      tx_n++;
    end
    if (pv_valid && !pv_acc && (!tx_valid || tx_data !== pv_data)) tx_unstable++;
    pv_valid = tx_valid;
    pv_acc   = tx_ready;
    pv_data  = tx_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    @(posedge clk_24m);
    #1;
    rx_stb = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk_24m);
      if (!busy) done = 1'b1;
    end
    check(tag, {31'd0, done}, 32'd1);
    @(posedge clk_24m);
    #1;
  endtask

  task automatic check_read_bytes(input string tag, input int base, input logic [31:0] d);
    check({tag, "_txcnt"}, 32'(tx_n - base), 32'd5);
    check({tag, "_b0"}, {24'd0, tx_log[base]},     32'h82);
    check({tag, "_b1"}, {24'd0, tx_log[base + 1]}, {24'd0, d[31:24]});
    check({tag, "_b2"}, {24'd0, tx_log[base + 2]}, {24'd0, d[23:16]});
    check({tag, "_b3"}, {24'd0, tx_log[base + 3]}, {24'd0, d[15:8]});
    check({tag, "_b4"}, {24'd0, tx_log[base + 4]}, {24'd0, d[7:0]});
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tb, cb, pb, cyb;
    rst     = 1'b1;
    rx_data = 8'd0;
    rx_stb  = 1'b0;
    repeat (3) @(posedge clk_24m);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_wb_cyc", {31'd0, bus.wb_cyc}, 32'd0);
    check("rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
    check("rst_wb_addr", {16'd0, bus.wb_addr}, 32'd0);
    check("rst_wb_wdata", bus.wb_wdata, 32'd0);
    check("rst_wb_wmsk", {28'd0, bus.wb_wmsk}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk_24m);
    #1;

    // Write with ack in the first bus cycle.
    ack_on = 1'b1; ack_wait = 0;
    tb = tx_n; pb = cyc_pulses; cyb = cyc_cycles;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("wr_cyc_latency", {31'd0, bus.wb_cyc}, 32'd1);
    @(posedge clk_24m);
    #1;
    check("wr_tx_latency", {31'd0, tx_valid}, 32'd1);
    check("wr_cyc_dropped", {31'd0, bus.wb_cyc}, 32'd0);
    wait_idle(50, "wr_done");
    check("wr_pulses", 32'(cyc_pulses - pb), 32'd1);
    check("wr_cycles", 32'(cyc_cycles - cyb), 32'd1);
    check("wr_we", {31'd0, cap_we}, 32'd1);
    check("wr_addr", {16'd0, cap_addr}, 32'h0003);
    check("wr_wdata", cap_wdata, 32'hDEADBEEF);
    check("wr_wmsk", {28'd0, cap_wmsk}, 32'hF);
    check("wr_txcnt", 32'(tx_n - tb), 32'd1);
    check("wr_resp", {24'd0, tx_log[tb]}, 32'h81);

    // Read with three wait states.
    ack_wait = 3; rdata_v = 32'hCAFEF00D;
    tb = tx_n; pb = cyc_pulses; cyb = cyc_cycles;
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    wait_idle(50, "rd_done");
    check("rd_pulses", 32'(cyc_pulses - pb), 32'd1);
    check("rd_cycles", 32'(cyc_cycles - cyb), 32'd4);
    check("rd_addr", {16'd0, cap_addr}, 32'h1234);
    check("rd_we", {31'd0, cap_we}, 32'd0);
    check("rd_wmsk", {28'd0, cap_wmsk}, 32'h0);
    check_read_bytes("rd", tb, 32'hCAFEF00D);

    // Timeout: no ack at all.
    ack_on = 1'b0;
    tb = tx_n; pb = cyc_pulses; cyb = cyc_cycles;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
    wait_idle(100, "tmo_done");
    check("tmo_pulses", 32'(cyc_pulses - pb), 32'd1);
    check("tmo_cycles", 32'(cyc_cycles - cyb), 32'(TIMEOUT));
    check("tmo_txcnt", 32'(tx_n - tb), 32'd1);
    check("tmo_resp", {24'd0, tx_log[tb]}, 32'hEE);
    check("tmo_busy", {31'd0, busy}, 32'd0);

    // Backpressure on the read response, with stray bytes during it.
    ack_on = 1'b1; ack_wait = 0; rdata_v = 32'h12345678; bp_mode = 1'b1;
    tb = tx_n; pb = cyc_pulses; cb = tx_unstable;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h07);
    repeat (3) @(posedge clk_24m);
    #1;
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
    wait_idle(300, "bp_done");
    bp_mode = 1'b0;
    repeat (2) @(posedge clk_24m);
    #1;
    check("bp_pulses", 32'(cyc_pulses - pb), 32'd1);
    check("bp_stable", 32'(tx_unstable - cb), 32'd0);
    check("bp_idle_after", {31'd0, busy}, 32'd0);
    check_read_bytes("bp", tb, 32'h12345678);

    // Garbage bytes before a read are ignored.
    ack_wait = 1; rdata_v = 32'h0BADF00D;
    tb = tx_n; pb = cyc_pulses;
    send_byte(8'h55); send_byte(8'hFF);
    check("gb_ignored", {31'd0, busy}, 32'd0);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    wait_idle(50, "gb_done");
    check("gb_pulses", 32'(cyc_pulses - pb), 32'd1);
    check("gb_addr", {16'd0, cap_addr}, 32'h0001);
    check_read_bytes("gb", tb, 32'h0BADF00D);

    // Reset while a bus cycle is outstanding.
    ack_on = 1'b0;
    send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
    repeat (3) @(posedge clk_24m);
    #1;
    check("rstm_cyc_before", {31'd0, bus.wb_cyc}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstm_cyc_async", {31'd0, bus.wb_cyc}, 32'd0);
    check("rstm_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rstm_busy", {31'd0, busy}, 32'd0);
    @(posedge clk_24m);
    #1;
    rst = 1'b0;
    ack_on = 1'b1; ack_wait = 2;
    tb = tx_n; pb = cyc_pulses; cyb = cyc_cycles;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_idle(50, "rstm_wr_done");
    check("rstm_pulses", 32'(cyc_pulses - pb), 32'd1);
    check("rstm_cycles", 32'(cyc_cycles - cyb), 32'd3);
    check("rstm_addr", {16'd0, cap_addr}, 32'h0005);
    check("rstm_wdata", cap_wdata, 32'h11223344);
    check("rstm_we", {31'd0, cap_we}, 32'd1);
    check("rstm_txcnt", 32'(tx_n - tb), 32'd1);
    check("rstm_resp", {24'd0, tx_log[tb]}, 32'h81);

    check("bus_stable", 32'(bus_unstable), 32'd0);
    check("tx_stable_all", 32'(tx_unstable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_dbg_master.md
Name: wb_dbg_master

Overview:
- Byte-stream-driven Wishbone initiator: the master-side counterpart to the SoC's Wishbone peripherals.
- Parses a compact command protocol received from a byte source (debug UART RX path) and issues single 32-bit read/write cycles onto the shared Wishbone bus.
- Returns status and read data on a byte sink (UART TX path).
- Lets a host poke warmboot, SPI, RGB and USB registers without CPU involvement.

Parameters:
- AW, 16, Wishbone address width in words (1..16); lower AW bits of the received 16-bit address are used.
- TIMEOUT, 255, cycles to wait for wb_ack before aborting (1..65535).

Ports:
- clk_24m  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received byte.
- rx_stb  in  1  one-cycle strobe: rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  sink accepts byte when tx_valid & tx_ready.
- wb_addr  out  AW  Wishbone word address.
- wb_wdata  out  32  write data.
- wb_rdata  in  32  read data, sampled on the ack cycle.
- wb_wmsk  out  4  byte mask; always 4'hF during writes.
- wb_we  out  1  write enable.
- wb_cyc  out  1  cycle/strobe.
- wb_ack  in  1  slave acknowledge (may be combinational from wb_cyc).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: tx_valid=0, tx_data=0, wb_cyc=0, wb_we=0, wb_addr=0, wb_wdata=0, wb_wmsk=0, busy=0; state=IDLE; all counters 0.
- Protocol, all multi-byte fields MSB first:
  - Write: 0x01, A1, A0, D3, D2, D1, D0 -> response 0x81.
  - Read: 0x02, A1, A0 -> response 0x82, D3, D2, D1, D0.
  - Timeout on either command -> response single byte 0xEE.
- States: IDLE, ADDR, WDATA, BUS, RESP.
- IDLE:
  - rx_stb with 0x01 -> ADDR, we_pending=1.
  - rx_stb with 0x02 -> ADDR, we_pending=0.
  - Any other byte ignored; stay IDLE.
- ADDR:
  - Shift 2 bytes into a 16-bit address register.
  - After the 2nd byte: -> WDATA if write, else -> BUS.
- WDATA: shift 4 bytes into wdata; after the 4th -> BUS.
- BUS:
  - Entry cycle: assert wb_cyc=1, wb_we=we_pending, wb_wmsk=4'hF if write else 0.
  - wb_addr/wb_wdata registered and stable for the whole cycle.
  - Timer starts at 0 on entry and increments each cycle with wb_cyc high.
  - First cycle with wb_ack=1: capture wb_rdata; wb_cyc, wb_we and wb_wmsk low the next cycle (exactly one acked beat); load response; -> RESP.
  - Timer reaches TIMEOUT with no ack: drop wb_cyc next cycle; response=0xEE; -> RESP.
  - ack and timeout on the same cycle: ack wins.
- RESP:
  - Present bytes in order on tx_data with tx_valid=1; each advances only on tx_valid & tx_ready.
  - tx_data stable while tx_valid high and not accepted.
  - tx_ready may be held low indefinitely.
  - After the last byte accepted: tx_valid=0 next cycle; -> IDLE.
- Latency, combinational ack: last command byte -> wb_cyc high next cycle; ack in that cycle -> tx_valid high the following cycle.
- Bytes arriving in BUS or RESP are discarded; no queuing.
- No inter-byte timeout: a partial command waits indefinitely.
- Address bits above AW are discarded; wb_addr = addr[AW-1:0].
- rst asserted mid-operation: wb_cyc and tx_valid drop immediately (async); state returns to IDLE; partial command lost.

Test Plan:
- Write: send 01 00 03 DE AD BE EF, slave acks in 1st cycle -> one wb_cyc pulse, wb_we=1, wb_addr=0x0003, wb_wdata=0xDEADBEEF, wb_wmsk=F; tx emits 0x81 once.
- Read: send 02 12 34, slave returns 0xCAFEF00D with ack after 3 wait cycles -> wb_cyc high 4 cycles, wb_addr=0x1234, wb_we=0; tx emits 82 CA FE F0 0D in order.
- Timeout: TIMEOUT=16, read with no ack -> wb_cyc high exactly 16 cycles then low; tx emits 0xEE; busy returns 0.
- Backpressure: read response with tx_ready low 10 cycles per byte -> each byte held stable, no loss/duplication; extra rx bytes sent meanwhile ignored.
- Garbage/idle: send 0x55 0xFF then 02 00 01 -> first two ignored, read of 0x0001 executed normally.
- Reset mid-cycle: assert rst during BUS with wb_cyc=1 -> wb_cyc=0 immediately; after release, a new write command completes normally.
